// File: rtl/epu_relu_stream.sv
// epu_relu_stream
// ---------------
// Streaming FP32 ReLU stage. It accepts one NRows x NCols result tile in
// row-major order from the systolic array drain. Each element with its sign
// bit set is replaced by zero; every other element passes bit-exact. Results
// are forwarded with their row/column tag to the writeback buffer.
//
// A 2-entry output buffer lets the stage sustain one element per cycle under
// backpressure. The input ready is derived from registered state only, so
// there is no combinational path from out_ready to in_ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   start / busy / done   tile control: start honoured in IDLE only,
//                         busy in RUN/DRAIN, done is a one-cycle pulse
//   in_valid / in_ready / in_data                     upstream element stream
//   out_valid / out_ready / out_data / out_row / out_col / out_last
//                                                     downstream tagged stream
//   clamp_count           elements zeroed in the current or last tile
module epu_relu_stream #(
    parameter  int NRows  = 8,
    parameter  int NCols  = 8,
    parameter  int Data_W = 32,
    localparam int N      = NRows * NCols,
    localparam int RW     = (NRows > 1) ? $clog2(NRows) : 1,
    localparam int CW     = (NCols > 1) ? $clog2(NCols) : 1,
    localparam int KW     = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [Data_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Data_W-1:0] out_data,
    output logic [RW-1:0]     out_row,
    output logic [CW-1:0]     out_col,
    output logic              out_last,
    output logic [KW-1:0]     clamp_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [Data_W-1:0] data;
        logic [RW-1:0]     row;
        logic [CW-1:0]     col;
        logic              last;
    } entry_t;

    // Sign-bit ReLU: -0, -inf and negative NaN all collapse to +0.
    function automatic logic [Data_W-1:0] relu(input logic [Data_W-1:0] x);
        logic [Data_W-1:0] y;
        if (x[Data_W-1]) begin
            y = {Data_W{1'b0}};
        end else begin
            y = x;
        end
        return y;
    endfunction

    state_t          state_r;
    logic            busy_r;
    logic            done_r;
    logic [KW-1:0]   in_cnt_r;
    logic [RW-1:0]   row_r;
    logic [CW-1:0]   col_r;
    logic [KW-1:0]   clamp_r;
    logic [1:0]      buf_cnt_r;
    entry_t          head_r;
    entry_t          tail_r;

    logic            in_ready_s;
    logic            push_s;
    logic            pop_s;
    entry_t          new_s;

    // Handshake decode and the tagged entry built from the incoming element.
    always_comb begin
        in_ready_s = (state_r == ST_RUN) && (in_cnt_r < KW'(N)) && (buf_cnt_r < 2'd2);
        push_s     = in_valid && in_ready_s;
        pop_s      = (buf_cnt_r != 2'd0) && out_ready;
        new_s.data = relu(in_data);
        new_s.row  = row_r;
        new_s.col  = col_r;
        new_s.last = (in_cnt_r == KW'(N - 1));
    end

    // Tile FSM with element, row/column and clamp counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            in_cnt_r <= {KW{1'b0}};
            row_r    <= {RW{1'b0}};
            col_r    <= {CW{1'b0}};
            clamp_r  <= {KW{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r  <= ST_RUN;
                        busy_r   <= 1'b1;
                        in_cnt_r <= {KW{1'b0}};
                        row_r    <= {RW{1'b0}};
                        col_r    <= {CW{1'b0}};
                        clamp_r  <= {KW{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (push_s && (in_cnt_r == KW'(N - 1))) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave on the edge that pops the final element so done
                    // lands in the cycle right after that handshake.
                    if ((buf_cnt_r == 2'd0) || (pop_s && (buf_cnt_r == 2'd1))) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase

            if (push_s) begin
                in_cnt_r <= in_cnt_r + KW'(1);
                if (col_r == CW'(NCols - 1)) begin
                    col_r <= {CW{1'b0}};
                    row_r <= (row_r == RW'(NRows - 1)) ? {RW{1'b0}} : row_r + RW'(1);
                end else begin
                    col_r <= col_r + CW'(1);
                end
                if (in_data[Data_W-1]) begin
                    clamp_r <= clamp_r + KW'(1);
                end
            end
        end
    end

    // Two-entry output buffer; head_r always holds the element on the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_cnt_r <= 2'd0;
            head_r    <= '0;
            tail_r    <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (buf_cnt_r == 2'd0) begin
                        head_r <= new_s;
                    end else begin
                        tail_r <= new_s;
                    end
                    buf_cnt_r <= buf_cnt_r + 2'd1;
                end
                2'b01: begin
                    head_r    <= tail_r;
                    buf_cnt_r <= buf_cnt_r - 2'd1;
                end
                2'b11: begin
                    // Push needs buf_cnt<2 and pop needs buf_cnt>0, so exactly
                    // one entry is present and the new one becomes the head.
                    head_r <= new_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign in_ready    = in_ready_s;
    assign out_valid   = (buf_cnt_r != 2'd0);
    assign out_data    = head_r.data;
    assign out_row     = head_r.row;
    assign out_col     = head_r.col;
    assign out_last    = head_r.last;
    assign clamp_count = clamp_r;

endmodule

// File: tb/tb_epu_relu_stream.sv
module tb_epu_relu_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 2x2 instance
    logic        s_start, s_busy, s_done, s_in_valid, s_in_ready;
    logic        s_out_valid, s_out_ready, s_out_last;
    logic [31:0] s_in_data, s_out_data;
    logic [0:0]  s_out_row, s_out_col;
    logic [2:0]  s_clamp;

    // default 8x8 instance
    logic        b_start, b_busy, b_done, b_in_valid, b_in_ready;
    logic        b_out_valid, b_out_ready, b_out_last;
    logic [31:0] b_in_data, b_out_data;
    logic [2:0]  b_out_row, b_out_col;
    logic [6:0]  b_clamp;

    epu_relu_stream #(.NRows(2), .NCols(2), .Data_W(32)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_row(s_out_row), .out_col(s_out_col), .out_last(s_out_last),
        .clamp_count(s_clamp)
    );

    epu_relu_stream u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_row(b_out_row), .out_col(b_out_col), .out_last(b_out_last),
        .clamp_count(b_clamp)
    );

    typedef struct packed {
        logic [31:0] din;
        logic [31:0] dout;
        logic        row;
        logic        col;
        logic        last;
    } vec_t;

    int tests = 0;
    int fails = 0;

    int in_idx, out_idx, done_cnt, cyc_n, busy_bad;
    int first_acc, last_acc, first_out, last_out, done_e;
    int exp_clamp;
    logic        stall_prev;
    logic [38:0] held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Element k of every 8x8 tile: mix of positives, negatives and FP specials.
    function automatic logic [31:0] gen(input int k);
        logic [31:0] v;
        if (k == 5)           v = 32'h7F80_0000;   // +inf
        else if (k == 6)      v = 32'hFF80_0000;   // -inf
        else if (k == 7)      v = 32'hFFC0_0001;   // negative NaN
        else if (k == 9)      v = 32'h8000_0000;   // -0
        else if (k == 11)     v = 32'h7FC0_0000;   // +NaN
        else if (k % 3 == 0)  v = 32'hC000_0000 | 32'(k);
        else                  v = 32'h4000_0000 | 32'(k);
        return v;
    endfunction

    function automatic logic [31:0] exp_relu(input logic [31:0] v);
        return v[31] ? 32'h0000_0000 : v;
    endfunction

    // One cycle on the 8x8 instance: sample at negedge, then advance an edge.
    task automatic cyc();
        @(negedge clk);
        if (stall_prev)
            chk("stall_hold", {24'h0, b_out_valid, b_out_data, b_out_row, b_out_col, b_out_last},
                {24'h0, 1'b1, held});
        stall_prev = b_out_valid && !b_out_ready;
        held = {b_out_data, b_out_row, b_out_col, b_out_last};
        if (b_in_valid && b_in_ready) begin
            if (in_idx == 0) first_acc = cyc_n + 1;
            last_acc = cyc_n + 1;
            in_idx++;
        end
        if (b_out_valid && b_out_ready) begin
            chk("out_elem", {25'h0, b_out_data, b_out_row, b_out_col, b_out_last},
                {25'h0, exp_relu(gen(out_idx)), 3'(out_idx / 8), 3'(out_idx % 8), (out_idx == 63)});
            if (out_idx == 0) first_out = cyc_n + 1;
            last_out = cyc_n + 1;
            out_idx++;
        end
        if (b_done) done_cnt++;
        @(posedge clk);
        #1;
        cyc_n++;
        b_in_data = gen(in_idx);
    endtask

    task automatic begin_tile();
        in_idx = 0; out_idx = 0; busy_bad = 0; stall_prev = 1'b0;
        b_in_data = gen(0);
        b_start = 1'b1;
        cyc();
        b_start = 1'b0;
        done_cnt = 0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (b_done) begin
                done_e = cyc_n;
                break;
            end
            if (!b_busy) busy_bad++;
        end
        chk("done_seen", {63'h0, b_done}, 64'h1);
    endtask

    task automatic run_until_acc(input int n);
        for (int i = 0; i < 200 && in_idx < n; i++) cyc();
        chk("acc_reached", 64'(in_idx >= n), 64'h1);
    endtask

    vec_t vec [4];
    int   in_i, out_i, s_done_n, last_c, done_c, idx0, hi_cnt;

    initial begin
        vec[0] = '{din: 32'h3F80_0000, dout: 32'h3F80_0000, row: 1'b0, col: 1'b0, last: 1'b0};
        vec[1] = '{din: 32'hBF80_0000, dout: 32'h0000_0000, row: 1'b0, col: 1'b1, last: 1'b0};
        vec[2] = '{din: 32'h8000_0000, dout: 32'h0000_0000, row: 1'b1, col: 1'b0, last: 1'b0};
        vec[3] = '{din: 32'h7FC0_0000, dout: 32'h7FC0_0000, row: 1'b1, col: 1'b1, last: 1'b1};

        exp_clamp = 0;
        for (int k = 0; k < 64; k++) begin
            logic [31:0] g;
            g = gen(k);
            if (g[31]) exp_clamp++;
        end

        rst_n = 1'b0;
        s_start = 1'b0; s_in_valid = 1'b0; s_in_data = 32'h0; s_out_ready = 1'b0;
        b_start = 1'b0; b_in_valid = 1'b0; b_in_data = 32'h0; b_out_ready = 1'b0;
        in_idx = 0; out_idx = 0; done_cnt = 0; cyc_n = 0; busy_bad = 0;
        first_acc = 0; last_acc = 0; first_out = 0; last_out = 0; done_e = 0;
        stall_prev = 1'b0; held = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("reset_small", {s_busy, s_done, s_in_ready, s_out_valid, s_out_data, s_out_row,
                            s_out_col, s_out_last, s_clamp}, 64'h0);
        chk("reset_big", {b_busy, b_done, b_in_ready, b_out_valid, b_out_data, b_out_row,
                          b_out_col, b_out_last, b_clamp}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2x2 table-driven tile
        s_out_ready = 1'b1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        in_i = 0; out_i = 0; s_done_n = 0; last_c = -1; done_c = -2;
        for (int c = 0; c < 12; c++) begin
            s_in_valid = (in_i < 4);
            s_in_data  = vec[(in_i < 4) ? in_i : 0].din;
            @(negedge clk);
            if (s_out_valid && s_out_ready) begin
                if (out_i < 4) begin
                    chk("small_out", {27'h0, s_out_data, s_out_row, s_out_col, s_out_last},
                        {27'h0, vec[out_i].dout, vec[out_i].row, vec[out_i].col, vec[out_i].last});
                    if (out_i == 3) last_c = c;
                end else begin
                    chk("small_extra_out", 64'(out_i), 64'd3);
                end
                out_i++;
            end
            if (s_done) begin
                s_done_n++;
                done_c = c;
            end
            if (s_in_valid && s_in_ready) in_i++;
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        chk("small_out_count", 64'(out_i), 64'd4);
        chk("small_clamp", 64'(s_clamp), 64'd2);
        chk("small_done_count", 64'(s_done_n), 64'd1);
        chk("small_done_timing", 64'(done_c), 64'(last_c + 1));
        chk("small_busy_after", {63'h0, s_busy}, 64'h0);

        // 8x8 full throughput
        b_in_valid = 1'b1; b_out_ready = 1'b1;
        begin_tile();
        chk("big_busy_start", {63'h0, b_busy}, 64'h1);
        wait_done(300);
        chk("big_out_count", 64'(out_idx), 64'd64);
        chk("big_acc_back2back", 64'(last_acc - first_acc), 64'd63);
        chk("big_first_latency", 64'(first_out - first_acc), 64'd1);
        chk("big_out_back2back", 64'(last_out - first_out), 64'd63);
        chk("big_done_timing", 64'(done_e), 64'(last_out));
        chk("big_busy_high", 64'(busy_bad), 64'd0);
        chk("big_busy_in_done", {63'h0, b_busy}, 64'h0);
        chk("big_clamp", 64'(b_clamp), 64'(exp_clamp));
        repeat (3) cyc();
        chk("big_done_once", 64'(done_cnt), 64'd1);
        chk("big_clamp_hold", 64'(b_clamp), 64'(exp_clamp));

        // in_valid while IDLE, then start pulsed during RUN
        idx0 = in_idx;
        repeat (5) cyc();
        chk("idle_no_accept", 64'(in_idx), 64'(idx0));
        chk("idle_in_ready", {63'h0, b_in_ready}, 64'h0);
        begin_tile();
        run_until_acc(10);
        b_start = 1'b1;
        cyc();
        b_start = 1'b0;
        wait_done(300);
        repeat (3) cyc();
        chk("restart_ignored_in", 64'(in_idx), 64'd64);
        chk("restart_ignored_out", 64'(out_idx), 64'd64);
        chk("restart_done_once", 64'(done_cnt), 64'd1);

        // Backpressure: 5 stalled cycles mid-tile
        begin_tile();
        run_until_acc(20);
        idx0 = in_idx;
        hi_cnt = 0;
        b_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (b_in_ready) hi_cnt++;
        end
        chk("stall_in_ready_low", 64'(hi_cnt), 64'd0);
        chk("stall_accepts", 64'(in_idx - idx0), 64'd1);
        chk("stall_out_valid", {63'h0, b_out_valid}, 64'h1);
        b_out_ready = 1'b1;
        wait_done(300);
        chk("stall_out_count", 64'(out_idx), 64'd64);

        // Start in the done cycle
        begin_tile();
        chk("redone_clamp_clear", 64'(b_clamp), 64'd0);
        chk("redone_busy", {63'h0, b_busy}, 64'h1);
        wait_done(300);
        chk("redone_out_count", 64'(out_idx), 64'd64);
        chk("redone_clamp", 64'(b_clamp), 64'(exp_clamp));

        // Reset mid-tile after 10 accepts
        repeat (2) cyc();
        begin_tile();
        run_until_acc(10);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midreset_outputs", {b_busy, b_done, b_in_ready, b_out_valid, b_out_data, b_out_row,
                                 b_out_col, b_out_last, b_clamp}, 64'h0);
        in_idx = 0; out_idx = 0; done_cnt = 0; stall_prev = 1'b0;
        repeat (4) cyc();
        chk("midreset_no_done", 64'(done_cnt), 64'd0);
        chk("midreset_no_accept", 64'(in_idx), 64'd0);
        begin_tile();
        wait_done(300);
        repeat (2) cyc();
        chk("postreset_out_count", 64'(out_idx), 64'd64);
        chk("postreset_done_once", 64'(done_cnt), 64'd1);
        chk("postreset_clamp", 64'(b_clamp), 64'(exp_clamp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/epu_relu_stream.md
Name: epu_relu_stream

Overview:
Streaming FP32 ReLU stage in the EPU. It takes the row-major NRows x NCols result tile from the systolic array drain over a valid/ready stream. It applies sign-bit ReLU to each element and forwards the results, tagged with row and column, to the EPU writeback buffer over a second valid/ready stream. Tile-level start/busy/done control, a 2-entry output buffer for full throughput under backpressure, and a clamped-element counter.

Parameters:
NRows, 8, tile rows (>=1)
NCols, 8, tile columns (>=1)
Data_W, 32, element width; bit Data_W-1 is the sign bit
Derived: N = NRows*NCols; RW = max(1,$clog2(NRows)); CW = max(1,$clog2(NCols)); KW = $clog2(N+1)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  begin a tile; honoured only in IDLE
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse when the tile has fully drained
in_valid  in  1  upstream element valid
in_ready  out  1  stage accepts an element this cycle
in_data  in  Data_W  FP32 element, row-major order
out_valid  out  1  output element valid
out_ready  in  1  downstream accepts
out_data  out  Data_W  ReLU result
out_row  out  RW  row index of out_data
out_col  out  CW  column index of out_data
out_last  out  1  high with element N-1
clamp_count  out  KW  number of elements clamped in the current or last tile

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; buffer emptied and contents discarded; counters=0. Outputs: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, clamp_count=0. Reset mid-tile aborts the tile with no done.
- FSM:
  - IDLE: start=1 -> RUN; clear in_cnt, row/col counters and clamp_count.
  - RUN: once in_cnt reaches N -> DRAIN.
  - DRAIN: once the buffer is empty -> IDLE with done=1 for one cycle.
- start in RUN or DRAIN: ignored. start in the done cycle (state already IDLE): accepted.
- in_ready = (state==RUN) && (in_cnt<N) && (buf_cnt<2). It is registered-state only and has no combinational path from out_ready. in_valid outside RUN is never accepted.
- Accept on (in_valid && in_ready):
  - Push {relu(in_data), row, col, in_cnt==N-1} into the buffer.
  - Increment in_cnt. Column counter wraps NCols-1 -> 0 and advances the row.
  - If in_data[Data_W-1]=1, increment clamp_count.
- ReLU:
  - Sign bit set -> all zeros. This covers -0, -inf and negative NaN.
  - Otherwise the value is passed bit-exact, including +inf and +NaN.
- Output is the buffer head:
  - out_valid = buf_cnt>0.
  - Pop on out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data/row/col/last hold stable.
  - Push and pop in the same cycle are allowed; buf_cnt is unchanged.
- Latency: an element accepted at edge t is visible on out_valid after edge t (the next cycle); minimum 1 cycle.
- Throughput: 1 element/cycle sustained when out_ready=1.
- done asserts the cycle after the handshake of the out_last element. busy=0 in that same cycle.
- clamp_count holds its value in IDLE until the next accepted start.

Test Plan:
- NRows=NCols=2. start, then inputs 0x3F800000, 0xBF800000, 0x80000000, 0x7FC00000 with out_ready=1 -> outputs 0x3F800000, 0, 0, 0x7FC00000 at (row,col) (0,0),(0,1),(1,0),(1,1). out_last on the 4th output only. clamp_count=2. done pulses once, 1 cycle after the last handshake.
- Default 8x8, in_valid and out_ready held at 1 -> 64 handshakes on consecutive cycles. First out_valid 1 cycle after the first accept. busy high throughout. done after 65+ cycles. No bubbles.
- out_ready=0 for 5 cycles mid-tile -> in_ready drops after 2 buffered elements. out_data stays stable while stalled. No loss or duplication once released; order is preserved.
- in_valid=1 while IDLE, and start pulsed during RUN -> no accept in IDLE. The second start has no effect: element count stays N, exactly one done.
- rst_n=0 for 1 cycle after 10 accepted elements -> next cycle all outputs at reset values. No done. A new start then produces a full, correct tile.
- start asserted in the done cycle -> the new tile starts. clamp_count clears, and the first output is row 0, col 0.
